// File: rtl/frame_color_analyzer_if.sv
// Bus between the frame colour analyser and its surroundings: the frame-buffer
// read port plus the start / busy / result handshake towards the CPU side.
interface frame_color_analyzer_if #(
  parameter int AW = 15
);
  logic          start;
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          busy;
  logic          result_valid;
  logic [1:0]    color;
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_g;
  logic [AW:0]   cnt_b;

  // analyser side
  modport slave (
    input  start, mem_px_data,
    output mem_px_addr, busy, result_valid, color, cnt_r, cnt_g, cnt_b
  );

  // CPU / frame-buffer side
  modport master (
    output start, mem_px_data,
    input  mem_px_addr, busy, result_valid, color, cnt_r, cnt_g, cnt_b
  );
endinterface

// File: rtl/frame_color_analyzer.sv
// Frame colour analyser: reads one stored RGB332 frame pixel by pixel, counts
// red / green / blue pixels and reports the dominant colour.
// Read timing: the first SCAN cycle is an address setup cycle (address 0 is
// driven but not yet issued); address k is issued in the following cycles and
// its byte is counted one cycle later under r_vld. The last byte is counted in
// DRAIN, the winner is registered in DECIDE, and DONE holds the result.
module frame_color_analyzer #(
  parameter int AW      = 15,
  parameter int NPIX    = 19200,
  parameter int MIN_PIX = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  frame_color_analyzer_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_DRAIN  = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0]    C_NONE  = 2'd0;
  localparam logic [1:0]    C_RED   = 2'd1;
  localparam logic [1:0]    C_GREEN = 2'd2;
  localparam logic [1:0]    C_BLUE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   MIN_CNT   = (AW+1)'(MIN_PIX);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic          r_first;   // address setup cycle at the start of a scan
  logic          r_vld;     // mem_px_data carries a pixel of this scan
  logic [AW:0]   r_cnt_r;
  logic [AW:0]   r_cnt_g;
  logic [AW:0]   r_cnt_b;
  logic [1:0]    r_color;

  logic          w_busy;
  logic          w_result_valid;
  logic          w_launch;
  logic [1:0]    w_px_cls;
  logic [1:0]    w_win_cls;
  logic [AW:0]   w_win_cnt;

  // Pure per-pixel classifier; the three colour classes never overlap.
  function automatic logic [1:0] classify(input logic [7:0] px);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic [1:0] cls;
    r   = px[7:5];
    g   = px[4:2];
    b   = px[1:0];
    cls = C_NONE;
    if      (r >= 3'd4 && g <= 3'd2 && b <= 2'd1) cls = C_RED;
    else if (g >= 3'd4 && r <= 3'd2 && b <= 2'd1) cls = C_GREEN;
    else if (b >= 2'd2 && r <= 3'd2 && g <= 3'd2) cls = C_BLUE;
    return cls;
  endfunction

  assign w_px_cls = classify(io_bus.mem_px_data);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.start) w_next = S_SCAN;
      S_SCAN:   if (!r_first && r_addr == LAST_ADDR) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_DECIDE;
      S_DECIDE: w_next = S_DONE;
      S_DONE:   if (io_bus.start) w_next = S_SCAN;
      default:  w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    w_busy         = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      S_SCAN, S_DRAIN, S_DECIDE: w_busy         = 1'b1;
      S_DONE:                    w_result_valid = 1'b1;
      default: ;
    endcase
  end

  // A new scan begins on the cycle the FSM leaves IDLE or DONE.
  assign w_launch = (w_next == S_SCAN) && (r_state != S_SCAN);

  // Address generator and read-valid pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_first <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= (r_state == S_SCAN) && !r_first;
      if (w_launch) begin
        r_addr  <= '0;
        r_first <= 1'b1;
      end else if (r_state == S_SCAN) begin
        if (r_first)                  r_first <= 1'b0;
        else if (r_addr == LAST_ADDR) r_addr  <= '0;
        else                          r_addr  <= r_addr + ADDR_ONE;
      end
    end
  end

  // Per-class pixel counters, cleared when a scan is launched.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_launch) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
    end else if (r_vld) begin
      case (w_px_cls)
        C_RED:   r_cnt_r <= r_cnt_r + CNT_ONE;
        C_GREEN: r_cnt_g <= r_cnt_g + CNT_ONE;
        C_BLUE:  r_cnt_b <= r_cnt_b + CNT_ONE;
        default: ;
      endcase
    end
  end

  // Winner selection; ties resolve red over green over blue.
  always_comb begin
    w_win_cls = C_RED;
    w_win_cnt = r_cnt_r;
    if (r_cnt_g > w_win_cnt) begin
      w_win_cls = C_GREEN;
      w_win_cnt = r_cnt_g;
    end
    if (r_cnt_b > w_win_cnt) begin
      w_win_cls = C_BLUE;
      w_win_cnt = r_cnt_b;
    end
    if (w_win_cnt < MIN_CNT) w_win_cls = C_NONE;
  end

  // Result register, loaded in DECIDE and held through DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_launch)       r_color <= C_NONE;
    else if (r_state == S_DECIDE) r_color <= w_win_cls;
  end

  assign io_bus.mem_px_addr  = r_addr;
  assign io_bus.busy         = w_busy;
  assign io_bus.result_valid = w_result_valid;
  assign io_bus.color        = r_color;
  assign io_bus.cnt_r        = r_cnt_r;
  assign io_bus.cnt_g        = r_cnt_g;
  assign io_bus.cnt_b        = r_cnt_b;

endmodule

// File: tb/tb_frame_color_analyzer.sv
// Directed bench for frame_color_analyzer on a 16-pixel frame. Two instances
// share the frame and start pulse: one with MIN_PIX=4, one with MIN_PIX=8.
module tb_frame_color_analyzer;
  localparam int AW   = 15;
  localparam int NPIX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frame_color_analyzer_if #(.AW(AW)) bus4 ();
  frame_color_analyzer_if #(.AW(AW)) bus8 ();

  frame_color_analyzer #(.AW(AW), .NPIX(NPIX), .MIN_PIX(4)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus4.slave)
  );
  frame_color_analyzer #(.AW(AW), .NPIX(NPIX), .MIN_PIX(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .io_bus(bus8.slave)
  );

  always #5 clk = ~clk;

  // Frame buffer model: synchronous read, data one cycle after the address.
  logic [7:0] mem [NPIX];
  always @(posedge clk) begin
    bus4.mem_px_data <= mem[bus4.mem_px_addr[3:0]];
    bus8.mem_px_data <= mem[bus8.mem_px_addr[3:0]];
  end
  assign bus8.start = bus4.start;

  int checks = 0;
  int errors = 0;
  int alog [NPIX];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] a, input int na, input logic [7:0] b,
                      input int nb, input logic [7:0] c);
    for (int i = 0; i < NPIX; i++)
      mem[i] = (i < na) ? a : (i < na + nb) ? b : c;
  endtask

  // Drive start for one edge; returns just after that edge (edge t).
  task automatic pulse_start();
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  // Step until result_valid, counting edges after edge t and logging addresses.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!bus4.result_valid && lat < 100) begin
      step();
      lat++;
      if (lat >= 1 && lat <= NPIX) alog[lat-1] = int'(bus4.mem_px_addr);
    end
  endtask

  task automatic chk_counts(input string tag, input int r, input int g, input int b, input int c);
    chk({tag, "_cnt_r"}, bus4.cnt_r, r);
    chk({tag, "_cnt_g"}, bus4.cnt_g, g);
    chk({tag, "_cnt_b"}, bus4.cnt_b, b);
    chk({tag, "_color"}, bus4.color, c);
    chk({tag, "_busy"},  bus4.busy, 0);
    chk({tag, "_addr"},  bus4.mem_px_addr, 0);
  endtask

  initial begin
    int lat;
    int guard;
    bus4.start = 1'b0;
    fill(8'hFF, NPIX, 8'hFF, 0, 8'hFF);

    // reset state
    repeat (2) step();
    chk("rst_addr",  bus4.mem_px_addr, 0);
    chk("rst_busy",  bus4.busy, 0);
    chk("rst_rv",    bus4.result_valid, 0);
    chk("rst_color", bus4.color, 0);
    chk("rst_cnt",   {bus4.cnt_r, bus4.cnt_g}, 0);
    rst = 1'b0;
    step();

    // uniform red
    fill(8'hE0, NPIX, 8'h00, 0, 8'h00);
    pulse_start();
    chk("red_busy_t", bus4.busy, 1);
    chk("red_addr_t", bus4.mem_px_addr, 0);
    wait_done(0, lat);
    chk("red_lat", lat, 19);
    chk_counts("red", 16, 0, 0, 1);

    // mixed frame, started from DONE
    fill(8'h1C, 5, 8'h03, 7, 8'hFF);
    pulse_start();
    chk("mix_rv_drop", bus4.result_valid, 0);
    chk("mix_clr_r",   bus4.cnt_r, 0);
    chk("mix_busy",    bus4.busy, 1);
    wait_done(0, lat);
    chk("mix_lat", lat, 19);
    chk_counts("mix", 0, 5, 7, 3);
    for (int k = 0; k < NPIX; k++) chk($sformatf("mix_addr%0d", k), alog[k], k);

    // tie and threshold
    fill(8'hC0, 6, 8'h10, 6, 8'hFF);
    pulse_start();
    wait_done(0, lat);
    chk("tie_lat", lat, 19);
    chk_counts("tie", 6, 6, 0, 1);
    chk("thr_rv",    bus8.result_valid, 1);
    chk("thr_color", bus8.color, 0);
    chk("thr_cnt_r", bus8.cnt_r, 6);
    chk("thr_cnt_g", bus8.cnt_g, 6);
    chk("thr_cnt_b", bus8.cnt_b, 0);

    // start mid-scan is ignored
    fill(8'h03, 9, 8'hE0, 2, 8'h1C);
    pulse_start();
    repeat (5) step();
    pulse_start();
    chk("mid_busy", bus4.busy, 1);
    wait_done(6, lat);
    chk("mid_lat", lat, 19);
    chk_counts("mid", 2, 5, 9, 3);
    step();
    chk("mid_hold_rv", bus4.result_valid, 1);
    chk("mid_hold_b",  bus4.cnt_b, 9);

    // reset mid-scan
    pulse_start();
    guard = 0;
    while (bus4.mem_px_addr != 7 && guard < 50) begin
      step();
      guard++;
    end
    chk("rmid_reach7", bus4.mem_px_addr, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_addr",  bus4.mem_px_addr, 0);
    chk("rmid_busy",  bus4.busy, 0);
    chk("rmid_rv",    bus4.result_valid, 0);
    chk("rmid_color", bus4.color, 0);
    chk("rmid_cnt",   {bus4.cnt_r, bus4.cnt_g, bus4.cnt_b}, 0);
    repeat (25) step();
    chk("rmid_idle_rv",   bus4.result_valid, 0);
    chk("rmid_idle_busy", bus4.busy, 0);

    fill(8'hE0, 10, 8'h1C, 4, 8'h7F);
    pulse_start();
    wait_done(0, lat);
    chk("post_lat", lat, 19);
    chk_counts("post", 10, 4, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
